// File: rtl/ch_frame_sched.sv
// Frame sequencer: gates the FFT symbol stream into LTS + N data-symbol frames with a CYC_O gap per frame.
// Latency: one cycle from ACK_O to DAT_O/STB_O, 1 sample/cycle sustained while ACK_I is high.
// Backpressure: a pending STB_O without ACK_I holds DAT_O and withholds ACK_O. Macro CH_SCHED_LTS_AVG_EN enables LTS averaging.
module ch_frame_sched #(
  parameter int SYM_LEN = 64,
  parameter int NSYM_W  = 10,
  parameter int GAP_CYC = 8
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [31:0]       DAT_I,
  input  logic              WE_I,
  input  logic              STB_I,
  input  logic              CYC_I,
  output logic              ACK_O,
  output logic [31:0]       DAT_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I,
  input  logic              frm_start,
  input  logic [NSYM_W-1:0] frm_nsym,
  output logic              busy,
  output logic              frm_done,
  output logic              err_busy
);

  localparam int SW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LTS1,
    S_LTS,
    S_DATA,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     samp_cnt_q, samp_cnt_d;
  logic [NSYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [NSYM_W-1:0] nsym_q, nsym_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [31:0]       dat_q, dat_d;
  logic              stb_q, stb_d;
  logic              cyc_q, cyc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              in_val;
  logic              out_halt;
  logic              accepting;
  logic              ack;
  logic              samp_wrap;
  logic [NSYM_W-1:0] sym_nxt;
  logic [31:0]       lts_out;

  assign in_val    = WE_I & STB_I & CYC_I;
  assign out_halt  = stb_q & ~ACK_I;
  assign accepting = (state_q == S_LTS1) || (state_q == S_LTS) || (state_q == S_DATA);
  assign ack       = in_val & ~out_halt & accepting;
  assign samp_wrap = ack && (samp_cnt_q == SW'(SYM_LEN - 1));
  assign sym_nxt   = sym_cnt_q + NSYM_W'(1);

`ifdef CH_SCHED_LTS_AVG_EN
  logic [31:0] lts_buf [SYM_LEN];
  logic [31:0] buf_rd;
  logic [16:0] re_sum;
  logic [16:0] im_sum;

  // First LTS symbol is captured sample-by-sample; read back asynchronously during the second
  always_ff @(posedge CLK_I) begin
    if (ack && (state_q == S_LTS1)) begin
      lts_buf[samp_cnt_q] <= DAT_I;
    end
  end

  assign buf_rd  = lts_buf[samp_cnt_q];
  // 17-bit sum then drop the LSB: a floor halving, so the mean never overflows
  assign re_sum  = {buf_rd[15], buf_rd[15:0]}  + {DAT_I[15], DAT_I[15:0]};
  assign im_sum  = {buf_rd[31], buf_rd[31:16]} + {DAT_I[31], DAT_I[31:16]};
  assign lts_out = {im_sum[16:1], re_sum[16:1]};
`else
  assign lts_out = DAT_I;
`endif

  // Next-state, counter and output-register logic for the frame sequencer
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    nsym_d     = nsym_q;
    gap_cnt_d  = gap_cnt_q;
    dat_d      = dat_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (stb_q && ACK_I) begin
      stb_d = 1'b0;
    end
    if (ack) begin
      samp_cnt_d = samp_wrap ? '0 : samp_cnt_q + SW'(1);
    end
    if (frm_start && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frm_start) begin
          nsym_d     = frm_nsym;
          samp_cnt_d = '0;
          sym_cnt_d  = '0;
          cyc_d      = 1'b1;
`ifdef CH_SCHED_LTS_AVG_EN
          state_d    = S_LTS1;
`else
          state_d    = S_LTS;
`endif
        end
      end
`ifdef CH_SCHED_LTS_AVG_EN
      S_LTS1: begin
        if (samp_wrap) begin
          state_d = S_LTS;
        end
      end
`endif
      S_LTS: begin
        if (ack) begin
          dat_d = lts_out;
          stb_d = 1'b1;
        end
        if (samp_wrap) begin
          state_d = (nsym_q != '0) ? S_DATA : S_DRAIN;
        end
      end
      S_DATA: begin
        if (ack) begin
          dat_d = DAT_I;
          stb_d = 1'b1;
        end
        if (samp_wrap) begin
          sym_cnt_d = sym_nxt;
          if (sym_nxt == nsym_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Close the bus cycle only once the final sample has been taken
        if (!stb_q || ACK_I) begin
          cyc_d     = 1'b0;
          gap_cnt_d = GW'(GAP_CYC - 1);
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by RST_I low
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= S_IDLE;
      samp_cnt_q <= '0;
      sym_cnt_q  <= '0;
      nsym_q     <= '0;
      gap_cnt_q  <= '0;
      dat_q      <= '0;
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      nsym_q     <= nsym_d;
      gap_cnt_q  <= gap_cnt_d;
      dat_q      <= dat_d;
      stb_q      <= stb_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ACK_O    = ack;
  assign DAT_O    = dat_q;
  assign STB_O    = stb_q;
  assign CYC_O    = cyc_q;
  assign WE_O     = cyc_q;
  assign busy     = (state_q != S_IDLE);
  assign frm_done = done_q;
  assign err_busy = err_q;

endmodule

// File: tb/tb_ch_frame_sched.sv
// Randomized bench for ch_frame_sched: frame-level reference model feeding a scoreboard queue.
// Inputs change on the falling edge; everything is sampled 2 time units later, well before the rising edge.
// Build with CH_SCHED_LTS_AVG_EN defined to exercise the LTS averaging path.
module tb_ch_frame_sched;

  localparam int SYM = 64;
  localparam int GAP = 8;
`ifdef CH_SCHED_LTS_AVG_EN
  localparam int AVG = SYM;
`else
  localparam int AVG = 0;
`endif

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [31:0] DAT_I = '0;
  logic        WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O, STB_O, WE_O;
  logic        ACK_I = 1'b1;
  logic        frm_start = 1'b0;
  logic [9:0]  frm_nsym = '0;
  logic        busy, frm_done, err_busy;

  always #5 CLK_I = ~CLK_I;

  ch_frame_sched #(.SYM_LEN(SYM), .NSYM_W(10), .GAP_CYC(GAP)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I),
    .CYC_I(CYC_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I), .frm_start(frm_start), .frm_nsym(frm_nsym),
    .busy(busy), .frm_done(frm_done), .err_busy(err_busy)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          done_cnt = 0, err_cnt = 0;
  int          stb_hole = 0, gap_run = 0, cyc_cur = 0, cyc_last = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

`ifdef CH_SCHED_LTS_AVG_EN
  // Mean of two signed 16-bit components, rounded toward minus infinity
  function automatic logic [31:0] avg(input logic [31:0] a, input logic [31:0] b);
    int re, im;
    re = (int'($signed(a[15:0]))  + int'($signed(b[15:0])))  >>> 1;
    im = (int'($signed(a[31:16])) + int'($signed(b[31:16]))) >>> 1;
    return {im[15:0], re[15:0]};
  endfunction
`endif

  // Monitor: scoreboard pops on each output handshake plus bus-protocol rules
  initial begin
    logic        held_v = 1'b0;
    logic [31:0] held = '0;
    logic        prev_err = 1'b0, prev_done = 1'b0;
    forever begin
      @(negedge CLK_I);
      #2;
      if (!mon_en || !RST_I) begin
        held_v = 1'b0; prev_err = 1'b0; prev_done = 1'b0; cyc_cur = 0;
        continue;
      end
      chk1("we_eq_cyc", WE_O, CYC_O);
      if (held_v) begin
        chk("halt_dat_stable", DAT_O, held);
        chk1("halt_stb_stable", STB_O, 1'b1);
      end
      if (STB_O && !ACK_I) begin
        held_v = 1'b1;
        held = DAT_O;
        chk1("halt_no_ack", ACK_O, 1'b0);
      end else begin
        held_v = 1'b0;
      end
      if (STB_O && ACK_I) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got %h, wanted no output", DAT_O);
        end else begin
          chk("dat_o", DAT_O, exp_q.pop_front());
        end
      end
      if (STB_O) chk1("stb_inside_cyc", CYC_O, 1'b1);
      if (CYC_O && !STB_O) stb_hole++;
      if (busy && !CYC_O) gap_run++;
      if (CYC_O) cyc_cur++;
      else if (cyc_cur > 0) begin cyc_last = cyc_cur; cyc_cur = 0; end
      if (frm_done) begin
        done_cnt++;
        chk1("done_in_idle", busy, 1'b0);
        chk1("done_one_cycle", prev_done, 1'b0);
      end
      if (err_busy) begin
        err_cnt++;
        chk1("err_one_cycle", prev_err, 1'b0);
      end
      prev_err = err_busy;
      prev_done = frm_done;
    end
  end

  // Called on a falling edge; leaves the DUT out of reset on a later falling edge
  task automatic apply_reset();
    RST_I = 1'b0; STB_I = 1'b1; WE_I = 1'b1; CYC_I = 1'b1; ACK_I = 1'b1; frm_start = 1'b0;
    #2;
    chk("rst_dat_o", DAT_O, 32'h0);
    chk("rst_flags", 32'({CYC_O, STB_O, WE_O, busy, frm_done, err_busy, ACK_O}), 32'h0);
    exp_q.delete();
    repeat (3) @(negedge CLK_I);
    #2;
    chk("rst_hold_flags", 32'({CYC_O, STB_O, WE_O, busy, frm_done, err_busy, ACK_O}), 32'h0);
    @(negedge CLK_I);
    RST_I = 1'b1; STB_I = 1'b0;
  endtask

  // One frame: pause_at/err_at/rst_at are accepted-sample indices (-1 = off)
  task automatic run_frame(input int nsym, input bit rnd, input int pause_at,
                           input int err_at, input int rst_at, input bit contig);
    int          n_in, idx, cyc, pause, pause_tot, d0, e0;
    bit          paused, err_fired, err_chk, fire, aborted, seen_done;
    logic [31:0] smp[$];
    logic [31:0] t;
    logic        exp_acc;
    n_in = (nsym + 1) * SYM + AVG;
    for (int i = 0; i < n_in; i++) smp.push_back(contig ? 32'(i) : $urandom);
`ifdef CH_SCHED_LTS_AVG_EN
    if (contig) begin
      t = smp[0];       t[15:0] = 16'h4000; smp[0] = t;
      t = smp[1];       t[15:0] = 16'h8000; smp[1] = t;
      t = smp[2];       t[15:0] = 16'h7FFF; smp[2] = t;
      t = smp[SYM];     t[15:0] = 16'h2000; smp[SYM] = t;
      t = smp[SYM + 1]; t[15:0] = 16'h8000; smp[SYM + 1] = t;
      t = smp[SYM + 2]; t[15:0] = 16'h0001; smp[SYM + 2] = t;
    end
`endif
    t = '0;
    for (int i = 0; i < n_in; i++) begin
`ifdef CH_SCHED_LTS_AVG_EN
      if (i < SYM) continue;
      if (i < 2 * SYM) begin exp_q.push_back(avg(smp[i - SYM], smp[i])); continue; end
`endif
      exp_q.push_back(smp[i]);
    end
    stb_hole = 0; gap_run = 0; d0 = done_cnt; e0 = err_cnt;

    // Request cycle: a sample is offered but must not be taken in IDLE
    @(negedge CLK_I);
    frm_start = 1'b1; frm_nsym = 10'(nsym);
    STB_I = 1'b1; WE_I = 1'b1; CYC_I = 1'b1; ACK_I = 1'b1; DAT_I = 32'hDEADBEEF;
    #2;
    chk1("idle_no_ack", ACK_O, 1'b0);
    chk1("idle_not_busy", busy, 1'b0);

    idx = 0; cyc = 0; pause = 0; pause_tot = 0;
    paused = 0; err_fired = 0; err_chk = 0; aborted = 0;
    while (idx < n_in && cyc < 20000) begin
      @(negedge CLK_I);
      cyc++;
      frm_start = 1'b0;
      if (rst_at >= 0 && idx == rst_at) begin
        apply_reset();
        aborted = 1;
        break;
      end
      STB_I = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      WE_I  = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      CYC_I = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      DAT_I = smp[idx];
      if (pause > 0) begin
        ACK_I = 1'b0; pause--; pause_tot++;
      end else if (pause_at >= 0 && idx == pause_at && !paused) begin
        paused = 1; pause = 4; pause_tot++; ACK_I = 1'b0;
      end else begin
        ACK_I = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      fire = (idx == err_at) && !err_fired;
      if (fire) begin
        frm_start = 1'b1; frm_nsym = 10'($urandom); err_fired = 1;
      end
      #2;
      if (cyc == 1) chk1("cyc_rise_after_start", CYC_O, 1'b1);
      if (err_chk) chk1("err_busy_pulse", err_busy, 1'b1);
      err_chk = fire;
      exp_acc = WE_I & STB_I & CYC_I & ~(STB_O & ~ACK_I);
      chk1("ack_o", ACK_O, exp_acc);
      if (ACK_O) idx++;
    end
    if (idx < n_in && !aborted) begin
      total++; bad++;
      $display("FAIL frame_accept_timeout: got %0d samples, wanted %0d", idx, n_in);
    end
    if (aborted) return;

    // Tail: keep offering; nothing more may be accepted until done
    seen_done = 0;
    for (int k = 0; k < 3000 && !seen_done; k++) begin
      @(negedge CLK_I);
      frm_start = 1'b0;
      STB_I = 1'b1; WE_I = 1'b1; CYC_I = 1'b1; DAT_I = $urandom;
      ACK_I = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      #2;
      if (err_chk) begin chk1("err_busy_pulse", err_busy, 1'b1); err_chk = 0; end
      chk1("no_ack_after_frame", ACK_O, 1'b0);
      if (frm_done) seen_done = 1;
    end
    if (!seen_done) begin
      total++; bad++;
      $display("FAIL frame_done_timeout: got no frm_done, wanted one");
    end
    @(negedge CLK_I);
    STB_I = 1'b0;
    #3;
    chk("all_outputs_seen", 32'(exp_q.size()), 32'h0);
    chk("done_count", 32'(done_cnt - d0), 32'h1);
    chk("err_count", 32'(err_cnt - e0), (err_at >= 0) ? 32'h1 : 32'h0);
    chk("gap_cycles", 32'(gap_run), 32'(GAP));
    if (!rnd) begin
      chk("cyc_high_cycles", 32'(cyc_last), 32'(n_in + 1 + pause_tot));
      chk("stb_holes", 32'(stb_hole), 32'(1 + AVG));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge CLK_I);
    apply_reset();
    mon_en = 1'b1;
    // Contiguous 0..N-1 stream, continuous ACK_I
    run_frame(2, 1'b0, -1, -1, -1, 1'b1);
    // LTS only
    run_frame(0, 1'b0, -1, -1, -1, 1'b0);
    // 5-cycle ACK_I stall in the second data symbol
    run_frame(3, 1'b0, AVG + SYM + 70, -1, -1, 1'b0);
    // Frame request while busy
    run_frame(1, 1'b0, -1, AVG + 100, -1, 1'b0);
    // Reset at sample 30 of DATA, then a clean restart
    run_frame(2, 1'b0, -1, -1, AVG + SYM + 30, 1'b0);
    run_frame(1, 1'b0, -1, -1, -1, 1'b1);
    // Randomized traffic and backpressure
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 3);
      run_frame(n, 1'b1, -1,
                ($urandom_range(0, 1) != 0) ? $urandom_range(0, (n + 1) * SYM - 1) : -1,
                -1, 1'b0);
    end
    repeat (4) @(negedge CLK_I);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch_frame_sched.md
# ch_frame_sched

Frame sequencer placed between the FFT output and the channel estimator/equalizer. Gates the 64-sample frequency-domain symbol stream into frames of one long-training symbol (LTS) followed by a programmed number of data symbols. Opens and closes the downstream bus cycle so the estimator sees a fresh `CYC` rising edge per frame, and guarantees an idle gap long enough to drain its multiplier pipeline. Optionally averages the two LTS symbols before they reach the estimator.

## Interface

**Parameters**
- `SYM_LEN`, 64: samples per symbol.
- `NSYM_W`, 10: width of the data-symbol count.
- `GAP_CYC`, 8: minimum `CYC_O`-low cycles between frames. Must be ≥ estimator latency + 2.

**Ports**
- `CLK_I`, in, 1: clock.
- `RST_I`, in, 1: asynchronous, active-low reset.
- `DAT_I`, in, 32: input sample; Im[31:16], Re[15:0].
- `WE_I`, `STB_I`, `CYC_I`, in, 1 each: upstream master strobes.
- `ACK_O`, out, 1: sample accepted.
- `DAT_O`, out, 32: output sample, same format as `DAT_I`.
- `CYC_O`, `STB_O`, `WE_O`, out, 1 each: downstream strobes. `WE_O = CYC_O`.
- `ACK_I`, in, 1: downstream accept.
- `frm_start`, in, 1: one-cycle frame request.
- `frm_nsym`, in, `NSYM_W`: data symbols in the frame. Sampled with `frm_start`.
- `busy`, out, 1: state ≠ IDLE.
- `frm_done`, out, 1: one-cycle pulse when the state returns to IDLE.
- `err_busy`, out, 1: one-cycle pulse when `frm_start` arrives while `busy`.

## Operation

**States:** IDLE, LTS1 (only with averaging), LTS, DATA, DRAIN, GAP.

**Acceptance**
- `in_val = WE_I & STB_I & CYC_I`.
- `out_halt = STB_O & ~ACK_I`.
- `ACK_O = in_val & ~out_halt & (state ∈ {LTS1, LTS, DATA})`.
- Samples are never accepted in IDLE, DRAIN or GAP.

**Counters**
- `samp_cnt` (0..`SYM_LEN`-1) increments on each `ACK_O` and wraps to 0 at the end of each symbol.
- `sym_cnt` counts completed data symbols.

**Transitions**
- IDLE + `frm_start` → LTS1 (with averaging) or LTS. Latches `frm_nsym` and clears both counters.
- LTS1: accepted samples are written to the 64×32 buffer at `samp_cnt`. Nothing is output. At the wrap → LTS.
- LTS: each accepted sample is forwarded. At the wrap → DATA if the latched nsym ≠ 0, otherwise → DRAIN.
- DATA: forward samples. At the wrap, `sym_cnt`+1; when `sym_cnt` reaches the latched nsym → DRAIN.
- DRAIN: wait until the last output is taken (`STB_O & ACK_I`, or `STB_O` already low). Then deassert `CYC_O`, load the gap counter with `GAP_CYC`-1 → GAP.
- GAP: count down to 0 → IDLE, pulsing `frm_done`.
- `frm_start` in any state other than IDLE is ignored and pulses `err_busy`.

**Output register**
- On `ACK_O` in LTS/DATA: `DAT_O` ← sample (or the averaged sample), `STB_O` ← 1.
- Otherwise, if `ACK_I`: `STB_O` ← 0.
- `DAT_O` holds its value while halted.

**CYC_O**
- Set on leaving IDLE.
- Cleared on exiting DRAIN.

**Reset** (`RST_I` = 0 at any time, including mid-frame) asynchronously forces:
- state IDLE;
- all counters 0;
- `DAT_O` = 0;
- `CYC_O`, `STB_O`, `busy`, `frm_done`, `err_busy` = 0;
- buffer contents undefined.

## Timing

- A sample accepted at edge t is presented on `DAT_O`/`STB_O` after edge t, giving one cycle of latency.
- Sustained throughput is 1 sample/cycle while `ACK_I` is high.
- `CYC_O` rises on the edge after `frm_start`.
- The first `STB_O` is no earlier than the edge after the first `ACK_O`.
- A frame start-to-done takes at least (nsym+1)·64 + `GAP_CYC` + 2 cycles. With averaging, add 64.
- Upstream `CYC_I` dropping mid-symbol pauses acceptance without aborting. Counters hold.

## Configuration

- **`CH_SCHED_LTS_AVG_EN` defined:**
  - Two LTS symbols are consumed.
  - The first is buffered (distributed RAM, asynchronous read).
  - During LTS, each output component is `(sext17(buf) + sext17(in))[16:1]`, which truncates toward −∞.
- **Undefined:**
  - No LTS1 state and no buffer.
  - The single LTS symbol is forwarded unmodified.

## Test plan

- `frm_start` with nsym=2 and `ACK_I` tied high, 192 samples 0..191 → `DAT_O` sequence 0..191 with `STB_O` high continuously. `CYC_O` high for 193 cycles then low for 8. `frm_done` fires once.
- nsym=0 → exactly 64 outputs, then DRAIN → GAP → IDLE. `ACK_O` stays low for the 65th offered sample.
- `ACK_I` low for 5 cycles mid-DATA → `ACK_O` low and `DAT_O` stable throughout. No sample lost or duplicated, and counts stay aligned.
- `frm_start` while busy → `err_busy` pulses for 1 cycle. The frame is unaffected.
- Averaging: LTS1 Re=0x4000, LTS2 Re=0x2000 → 0x3000. 0x8000 + 0x8000 → 0x8000. 0x7FFF + 0x0001 → 0x4000. Exactly 64 outputs are emitted for 128 inputs.
- `RST_I` low at sample 30 of DATA → all outputs 0 immediately. A new `frm_start` after release restarts cleanly from LTS.
